// File: rtl/oam_dma.sv
// OAM DMA engine: on a CPU write to the DMA register, halts the CPU and
// copies one 256-byte page from the system bus into the OAM data port,
// alternating read and write cycles aligned to even bus cycles.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_r_w,
  input  logic [7:0]  bus_data_in,
  output logic        cpu_rdy,
  output logic        bus_grant,
  output logic [15:0] bus_addr,
  output logic        bus_r_w,
  output logic [7:0]  bus_data_out,
  output logic        busy,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    RD    = 3'd3,
    WR    = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       parity;
  logic [7:0] page;
  logic [7:0] index;
  logic [7:0] buffer;
  logic       trigger;
  logic       last_index;

  assign trigger    = (cpu_r_w == 1'b0) && (cpu_addr == DMA_REG_ADDR);
  assign last_index = (index == 8'hFF);

  // Next-state logic; a stalled CPU write in HALT keeps us there, and
  // ALIGN is inserted so that every RD lands on an even cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = HALT;
      HALT:    if (cpu_r_w) state_nxt = parity ? RD : ALIGN;
      ALIGN:   state_nxt = RD;
      RD:      state_nxt = WR;
      WR:      state_nxt = last_index ? IDLE : RD;
      default: state_nxt = IDLE;
    endcase
  end

  // State, cycle parity, transfer page/index and the read buffer.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state  <= IDLE;
      parity <= 1'b0;
      page   <= 8'h00;
      index  <= 8'h00;
      buffer <= 8'h00;
    end else begin
      state  <= state_nxt;
      parity <= ~parity;
      if (state == IDLE && trigger) begin
        page  <= cpu_data_out;
        index <= 8'h00;
      end
      if (state == RD) buffer <= bus_data_in;
      // index stays at FF after the last write; it never carries into page
      if (state == WR && !last_index) index <= index + 8'h01;
    end
  end

  // Outputs decoded from state and registers only (no cpu_* feedthrough).
  always_comb begin
    cpu_rdy      = 1'b1;
    bus_grant    = 1'b0;
    bus_addr     = 16'h0000;
    bus_r_w      = 1'b1;
    bus_data_out = 8'h00;
    busy         = 1'b0;
    dma_done     = 1'b0;
    case (state)
      HALT, ALIGN: begin
        cpu_rdy = 1'b0;
        busy    = 1'b1;
      end
      RD: begin
        cpu_rdy   = 1'b0;
        busy      = 1'b1;
        bus_grant = 1'b1;
        bus_addr  = {page, index};
      end
      WR: begin
        cpu_rdy      = 1'b0;
        busy         = 1'b1;
        bus_grant    = 1'b1;
        bus_r_w      = 1'b0;
        bus_addr     = OAM_DATA_ADDR;
        bus_data_out = buffer;
        dma_done     = last_index;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: page copies with both cycle alignments,
// stalled CPU writes in HALT, ignored re-trigger, page FF and mid-transfer reset.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_r_w;
  logic [7:0]  bus_data_in;
  logic        cpu_rdy;
  logic        bus_grant;
  logic [15:0] bus_addr;
  logic        bus_r_w;
  logic [7:0]  bus_data_out;
  logic        busy;
  logic        dma_done;

  int tests = 0;
  int fails = 0;

  // parity of the current cycle as the bench sees it: 0 on the first cycle after reset
  logic tb_par;

  oam_dma #(.DMA_REG_ADDR(16'h4014), .OAM_DATA_ADDR(16'h2004)) dut (
    .clk(clk), .reset_l(reset_l), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_r_w(cpu_r_w), .bus_data_in(bus_data_in), .cpu_rdy(cpu_rdy),
    .bus_grant(bus_grant), .bus_addr(bus_addr), .bus_r_w(bus_r_w),
    .bus_data_out(bus_data_out), .busy(busy), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_par <= reset_l ? ~tb_par : 1'b0;

  // memory model: page 02 holds i^5A at 0x0200+i
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h58;
  endfunction

  always_comb bus_data_in = mem(bus_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cpu_idle();
    cpu_addr     = 16'h0000;
    cpu_data_out = 8'h00;
    cpu_r_w      = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " cpu_rdy"}, cpu_rdy, 1);
    chk({tag, " bus_grant"}, bus_grant, 0);
    chk({tag, " bus_addr"}, bus_addr, 0);
    chk({tag, " bus_r_w"}, bus_r_w, 1);
    chk({tag, " bus_data_out"}, bus_data_out, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " dma_done"}, dma_done, 0);
  endtask

  // One complete transfer. halt_even selects the parity of the first HALT
  // cycle; hold_w stalls that many CPU write cycles in HALT; retrig writes a
  // different page to the DMA register mid-transfer.
  task automatic do_dma(input string tag, input logic [7:0] pg, input bit halt_even,
                        input int hold_w, input bit retrig);
    int low_cnt = 0, pre_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int rd_err = 0, wr_err = 0;
    int exp_pre;
    bit fin = 0, retrig_done = 0;
    logic last_par;
    logic [15:0] last_rd = 16'h0000;
    // position the trigger write so the following HALT cycle has the wanted parity
    for (int w = 0; w < 4 && tb_par !== (halt_even ? 1'b1 : 1'b0); w++) @(negedge clk);
    cpu_addr = 16'h4014; cpu_data_out = pg; cpu_r_w = 1'b0;
    for (int c = 0; c < 700 && !fin; c++) begin
      @(negedge clk);
      if (cpu_rdy) begin
        fin = 1;
      end else begin
        low_cnt++;
        if (!bus_grant && rd_cnt == 0) pre_cnt++;
        if (bus_grant && bus_r_w) begin
          if (bus_addr !== {pg, rd_cnt[7:0]} || tb_par !== 1'b0) rd_err++;
          last_rd = bus_addr;
          rd_cnt++;
        end
        if (bus_grant && !bus_r_w) begin
          if (bus_addr !== 16'h2004 || bus_data_out !== mem({pg, wr_cnt[7:0]})) wr_err++;
          if (dma_done) done_cnt++;
          if (dma_done !== (wr_cnt == 255)) wr_err++;
          wr_cnt++;
        end else if (dma_done) begin
          wr_err++;
        end
      end
      if (c < hold_w) begin
        cpu_addr = 16'h0300; cpu_data_out = 8'h77; cpu_r_w = 1'b0;
      end else if (retrig && !retrig_done && wr_cnt == 10) begin
        cpu_addr = 16'h4014; cpu_data_out = ~pg; cpu_r_w = 1'b0;
        retrig_done = 1;
      end else begin
        cpu_idle();
      end
    end
    last_par = (halt_even ? 1'b0 : 1'b1) ^ hold_w[0];
    exp_pre  = 1 + hold_w + ((last_par == 1'b0) ? 1 : 0);
    chk({tag, " finished"}, fin, 1);
    chk({tag, " pre-read stall"}, pre_cnt, exp_pre);
    chk({tag, " cpu_rdy low cycles"}, low_cnt, exp_pre + 512);
    chk({tag, " reads"}, rd_cnt, 256);
    chk({tag, " writes"}, wr_cnt, 256);
    chk({tag, " read addr/parity errs"}, rd_err, 0);
    chk({tag, " write errs"}, wr_err, 0);
    chk({tag, " dma_done pulses"}, done_cnt, 1);
    chk({tag, " last read"}, last_rd, {pg, 8'hFF});
    chk({tag, " busy after"}, busy, 0);
    chk({tag, " grant after"}, bus_grant, 0);
  endtask

  initial begin
    int wc;
    bit hit;
    reset_l = 1'b0;
    cpu_idle();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset_l = 1'b1;
    @(negedge clk);
    check_idle_outputs("post-reset");

    // ignored in IDLE: a CPU read of the DMA register does not trigger
    cpu_addr = 16'h4014; cpu_r_w = 1'b1; cpu_data_out = 8'h02;
    @(negedge clk);
    cpu_idle();
    @(negedge clk);
    chk("read no trigger busy", busy, 0);

    do_dma("even-halt", 8'h02, 1'b1, 0, 1'b0);   // 514 cycles with ALIGN
    do_dma("odd-halt",  8'h02, 1'b0, 0, 1'b0);   // 513 cycles, no ALIGN
    do_dma("halt-hold", 8'h02, 1'b0, 2, 1'b0);   // HALT lasts 3 cycles
    do_dma("retrig",    8'h02, 1'b1, 0, 1'b1);   // second write ignored
    do_dma("page-ff",   8'hFF, 1'b0, 0, 1'b0);   // ends at FFFF

    // reset asserted for one cycle during the WR of index 40
    cpu_addr = 16'h4014; cpu_data_out = 8'h04; cpu_r_w = 1'b0;
    wc = 0; hit = 0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk);
      cpu_idle();
      if (bus_grant && !bus_r_w) begin
        if (wc == 8'h40) begin
          reset_l = 1'b0;
          hit = 1;
        end
        wc++;
      end
    end
    chk("reset reached idx40 WR", hit, 1);
    @(negedge clk);
    reset_l = 1'b1;
    check_idle_outputs("abort");
    @(negedge clk);
    chk("abort stays idle", busy, 0);
    do_dma("after-abort", 8'h03, 1'b1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
